ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Upstream feeder for the 16x8 program RAM.
- Accepts a byte stream over a valid/ready handshake and writes it to sequential RAM addresses starting at 0, using the RAM's manual-programming port (program_mode, addr_in_manual, data_in_manual, load_manual).
- Optionally verifies a trailing two's-complement checksum byte.
- Lets a host or boot ROM program the processor without toggling switches.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM/stream data width.
- STROBE_CYCLES, 1, cycles load_out is held high per write (>=1).
- CHECKSUM_EN, 1, 1 = expect a checksum byte after the payload.

Ports:
- clk  input  1  system clock, all logic on posedge.
- clr  input  1  synchronous active-high reset.
- start  input  1  begin a load session; sampled only in IDLE.
- abort  input  1  cancel an active session.
- len_in  input  ADDR_W+1  payload byte count; legal range 1..16, latched on start.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- program_mode  output  1  drives the RAM program_mode; high for the whole session.
- addr_out  output  ADDR_W  drives the RAM addr_in_manual.
- data_out  output  DATA_W  drives the RAM data_in_manual.
- load_out  output  1  drives the RAM load_manual; write strobe.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky; cleared by clr or an accepted start.
- loaded_cnt  output  ADDR_W+1  bytes written in the current/last session.

Behaviour:
- Reset (clr=1 at posedge):
  - state=IDLE.
  - All outputs 0: program_mode, addr_out, data_out, load_out, in_ready, busy, done, error, loaded_cnt.
  - Internal sum=0.
  - clr overrides every other input, including mid-strobe: load_out is 0 in the cycle after clr.
- The RAM write is level-sensitive, so the write protocol is fixed: addr_out/data_out stable for one full cycle before load_out rises, during the strobe, and for one cycle after it falls.
- States: IDLE, WAIT_BYTE, SETUP, STROBE, HOLD, CHECK, DONE, ERR.
- IDLE:
  - On start, if len_in is 0 or >16: go to ERR.
  - Otherwise: latch len, addr_out=0, sum=0, loaded_cnt=0, error=0, program_mode=1, go to WAIT_BYTE.
- WAIT_BYTE:
  - in_ready=1.
  - On in_valid&in_ready: data_out<=in_data, sum<=sum+in_data (mod 256), go to SETUP.
- SETUP: 1 cycle, load_out=0, then STROBE.
- STROBE:
  - load_out=1 for exactly STROBE_CYCLES cycles; the counter restarts on each entry.
  - Then HOLD.
- HOLD: 1 cycle, load_out=0, loaded_cnt++.
  - If addr_out==len-1: go to CHECK if CHECKSUM_EN, else DONE.
  - Otherwise: addr_out++ and go to WAIT_BYTE.
- CHECK:
  - in_ready=1.
  - On handshake: if (sum+in_data) mod 256 == 0, go to DONE; else ERR.
  - The checksum byte is never written to RAM.
- DONE: done=1 for one cycle, program_mode<=0, go to IDLE.
- ERR: error<=1, program_mode<=0, go to IDLE.
- Hold behaviour: addr_out, data_out and loaded_cnt keep their last values in IDLE.
- in_ready is high only in WAIT_BYTE and CHECK. in_data is ignored elsewhere, and a held in_valid is not consumed.
- Throughput: 3+STROBE_CYCLES cycles per byte with in_valid held high; first in_ready is the cycle after start.
- abort in any non-IDLE state:
  - Next cycle: load_out=0, program_mode=0, error=1, state=IDLE.
  - A write already strobed is not undone.
  - abort in IDLE is ignored; start with abort in IDLE takes start.
  - abort has priority over a same-cycle handshake; that byte is not accepted.
- start while busy is ignored.
- len=16: addr_out reaches 15 and never wraps.

Decomposition:
- Package ram_loader_pkg:
  - state enum (3-bit encoding).
  - MAX_LEN=16.
  - CHK_OK=8'h00.
- Optional sub-module ram_write_strober: SETUP/STROBE/HOLD timing, driven by a go pulse, returning a done pulse. The main FSM owns the handshake, address and checksum.

Test Plan:
- len_in=3, CHECKSUM_EN=1, stream 8'h1E, 8'h2F, 8'h50, checksum 8'h63:
  - load_out pulses at addr 0,1,2 with data 1E/2F/50, each preceded and followed by a low cycle at stable addr/data.
  - done pulses once, error=0, loaded_cnt=3, program_mode falls with done.
- Same stream with checksum 8'h64 -> three writes occur, error=1, no done, program_mode=0.
- len_in=16 with in_valid held high, bytes 0..15 -> writes at addr 0..15, 4 cycles/byte (STROBE_CYCLES=1), no wrap past 15.
- len_in=0 and len_in=17 -> no load_out, error=1 within 2 cycles; a subsequent legal start clears error.
- abort asserted during STROBE of byte 2 -> load_out low next cycle, program_mode=0, error=1, busy=0, in_ready=0. clr mid-STROBE -> all outputs 0 next cycle.
- in_valid gaps of 5 cycles between bytes plus start pulses while busy -> writes unaffected, start ignored, in_ready high only while waiting.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the program-RAM loader.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] CHK_OK  = 8'h00;

endpackage

// File: rtl/ram_loader.sv
// Streams bytes into the 16x8 program RAM through its manual-programming
// port, with an optional trailing two's-complement checksum.
module ram_loader #(
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 1,
    parameter int CHECKSUM_EN   = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              program_mode,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              load_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   loaded_cnt
);
    import ram_loader_pkg::*;

    localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [SW-1:0] STRB_LAST = SW'(STROBE_CYCLES - 1);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [DATA_W-1:0] SUM_OK = DATA_W'(CHK_OK);

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_sum;
    logic [ADDR_W:0]   r_cnt;
    logic [SW-1:0]     r_strb;
    logic              r_err;
    logic              r_pmode;

    logic              w_len_bad;
    logic [ADDR_W:0]   w_addr_p1;
    logic              w_last;
    logic [DATA_W-1:0] w_chk;

    assign w_len_bad = (len_in == '0) || (len_in > LEN_MAX);
    assign w_addr_p1 = {1'b0, r_addr} + (ADDR_W + 1)'(1);
    assign w_last    = (w_addr_p1 == r_len);
    assign w_chk     = r_sum + in_data;

    // Outputs decode the state register only, so they are glitch-free.
    assign in_ready     = (r_state == S_WAIT_BYTE) || (r_state == S_CHECK);
    assign load_out     = (r_state == S_STROBE);
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign error        = r_err;
    assign program_mode = r_pmode;
    assign addr_out     = r_addr;
    assign data_out     = r_data;
    assign loaded_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
            r_pmode <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_pmode <= 1'b0;
            r_err   <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_bad) begin
                            r_state <= S_ERR;
                        end else begin
                            r_len   <= len_in;
                            r_addr  <= '0;
                            r_sum   <= '0;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                            r_pmode <= 1'b1;
                            r_state <= S_WAIT_BYTE;
                        end
                    end
                end
                S_WAIT_BYTE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_sum   <= w_chk;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_strb  <= '0;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_strb == STRB_LAST) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_strb <= r_strb + 1'b1;
                    end
                end
                S_HOLD: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Address only advances after the hold cycle.
                    if (w_last) begin
                        r_state <= (CHECKSUM_EN != 0) ? S_CHECK : S_DONE;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_WAIT_BYTE;
                    end
                end
                S_CHECK: begin
                    if (in_valid) begin
                        r_state <= (w_chk == SUM_OK) ? S_DONE : S_ERR;
                    end
                end
                S_DONE: begin
                    r_pmode <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_err   <= 1'b1;
                    r_pmode <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected RAM writes are queued as
// bytes are driven and matched against each load_out strobe.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       clr, start, abort, in_valid;
    logic [4:0] len_in;
    logic [7:0] in_data;
    logic       in_ready, program_mode, load_out, busy, done, error;
    logic [3:0] addr_out;
    logic [7:0] data_out;
    logic [4:0] loaded_cnt;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    int          rise_q[$];
    int          ncyc = 0;
    int          wr_cnt = 0;
    bit          skip_hold = 1'b0;
    logic [3:0]  exp_addr = '0;
    logic [3:0]  p_addr;
    logic [7:0]  p_data;
    logic        p_load = 1'b0;

    ram_loader #(
        .ADDR_W(4), .DATA_W(8), .STROBE_CYCLES(1), .CHECKSUM_EN(1)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .len_in(len_in), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .program_mode(program_mode),
        .addr_out(addr_out), .data_out(data_out), .load_out(load_out),
        .busy(busy), .done(done), .error(error), .loaded_cnt(loaded_cnt)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        logic [11:0] e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (load_out && !p_load) begin
                checks++;
                if (addr_out !== p_addr || data_out !== p_data) begin
                    errors++;
                    $display("FAIL setup_stable: addr %h data %h, required %h %h",
                             addr_out, data_out, p_addr, p_data);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, required none",
                             addr_out, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({addr_out, data_out} !== e) begin
                        errors++;
                        $display("FAIL write: addr/data %h/%h, required %h/%h",
                                 addr_out, data_out, e[11:8], e[7:0]);
                    end
                end
                rise_q.push_back(ncyc);
                wr_cnt++;
            end
            if (!load_out && p_load && !skip_hold) begin
                checks++;
                if (addr_out !== p_addr || data_out !== p_data) begin
                    errors++;
                    $display("FAIL hold_stable: addr %h data %h, required %h %h",
                             addr_out, data_out, p_addr, p_data);
                end
            end
            p_addr = addr_out;
            p_data = data_out;
            p_load = load_out;
        end
    endtask

    task automatic do_start(input logic [4:0] l);
        start    = 1'b1;
        len_in   = l;
        exp_addr = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit wr);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        if (wr) begin
            exp_q.push_back({exp_addr, b});
            exp_addr++;
        end
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_timeout: in_ready %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int dn);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_load(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = load_out;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({program_mode, addr_out, data_out, load_out, in_ready, busy,
             done, error, loaded_cnt} !== '0) begin
            errors++;
            $display("FAIL reset: pm %b addr %h data %h ld %b rdy %b busy %b dn %b err %b cnt %0d, required all 0",
                     program_mode, addr_out, data_out, load_out, in_ready,
                     busy, done, error, loaded_cnt);
        end
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_checksum_ok();
        int dn = 0;
        int w0 = wr_cnt;
        logic pm_d = 1'b0;
        logic pm_a = 1'b1;
        bit after = 1'b0;
        do_start(5'd3);
        @(negedge clk);
        checks++;
        if ({in_ready, busy, program_mode} !== 3'b111) begin
            errors++;
            $display("FAIL first_ready: rdy/busy/pm %b%b%b, required 111",
                     in_ready, busy, program_mode);
        end
        @(posedge clk); #1;
        send(8'h1E, 1'b1);
        send(8'h2F, 1'b1);
        send(8'h50, 1'b1);
        send(8'h63, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                pm_d = program_mode;
            end else if (dn == 1 && !after) begin
                pm_a  = program_mode;
                after = 1'b1;
            end
        end
        checks++;
        if (dn !== 1 || pm_d !== 1'b1 || pm_a !== 1'b0) begin
            errors++;
            $display("FAIL ok_done: pulses %0d pm@done %b pm@after %b, required 1 1 0",
                     dn, pm_d, pm_a);
        end
        checks++;
        if (error !== 1'b0 || loaded_cnt !== 5'd3) begin
            errors++;
            $display("FAIL ok_status: err %b cnt %0d, required 0 3", error, loaded_cnt);
        end
        checks++;
        if (wr_cnt - w0 !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL ok_writes: %0d writes %0d pending, required 3 0",
                     wr_cnt - w0, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_checksum_bad();
        int dn;
        int w0 = wr_cnt;
        do_start(5'd3);
        send(8'h1E, 1'b1);
        send(8'h2F, 1'b1);
        send(8'h50, 1'b1);
        send(8'h64, 1'b0);
        wait_done(dn);
        checks++;
        if (dn !== 0 || {error, program_mode, busy} !== 3'b100) begin
            errors++;
            $display("FAIL bad_sum: done %0d err/pm/busy %b%b%b, required 0 100",
                     dn, error, program_mode, busy);
        end
        checks++;
        if (wr_cnt - w0 !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL bad_sum_writes: %0d writes %0d pending, required 3 0",
                     wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_bad_len();
        logic [4:0] lens[2] = '{5'd0, 5'd17};
        int dn;
        int w0;
        for (int i = 0; i < 2; i++) begin
            w0 = wr_cnt;
            do_start(lens[i]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (error !== 1'b1 || busy !== 1'b0 || wr_cnt != w0) begin
                errors++;
                $display("FAIL bad_len %0d: err %b busy %b writes %0d, required 1 0 0",
                         lens[i], error, busy, wr_cnt - w0);
            end
            @(posedge clk); #1;
            do_start(5'd1);
            @(negedge clk);
            checks++;
            if (error !== 1'b0) begin
                errors++;
                $display("FAIL restart_clears %0d: err %b, required 0", lens[i], error);
            end
            @(posedge clk); #1;
            send(8'h10, 1'b1);
            send(8'hF0, 1'b0);
            wait_done(dn);
            checks++;
            if (dn !== 1 || error !== 1'b0 || exp_q.size() !== 0) begin
                errors++;
                $display("FAIL len1_session: done %0d err %b pending %0d, required 1 0 0",
                         dn, error, exp_q.size());
            end
        end
    endtask

    task automatic test_len16();
        logic [7:0] s = '0;
        int dn;
        int w0 = wr_cnt;
        rise_q.delete();
        do_start(5'd16);
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b1);
            s = s + 8'(i);
        end
        send(8'h00 - s, 1'b0);
        wait_done(dn);
        checks++;
        if (dn !== 1 || wr_cnt - w0 !== 16 || loaded_cnt !== 5'd16) begin
            errors++;
            $display("FAIL len16: done %0d writes %0d cnt %0d, required 1 16 16",
                     dn, wr_cnt - w0, loaded_cnt);
        end
        checks++;
        if (addr_out !== 4'd15 || rise_q.size() !== 16) begin
            errors++;
            $display("FAIL len16_end: addr %h strobes %0d, required f 16",
                     addr_out, rise_q.size());
        end
        for (int i = 1; i < rise_q.size(); i++) begin
            checks++;
            if (rise_q[i] - rise_q[i-1] !== 4) begin
                errors++;
                $display("FAIL rate byte %0d: %0d cycles, required 4",
                         i, rise_q[i] - rise_q[i-1]);
            end
        end
    endtask

    task automatic test_abort();
        bit seen;
        int w0 = wr_cnt;
        do_start(5'd3);
        send(8'hA1, 1'b1);
        send(8'hB2, 1'b1);
        send(8'hC3, 1'b1);
        wait_load(seen);
        checks++;
        if (!seen || addr_out !== 4'd2) begin
            errors++;
            $display("FAIL abort_strobe: load %b addr %h, required 1 2", seen, addr_out);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({load_out, program_mode, error, busy, in_ready} !== 5'b00100) begin
            errors++;
            $display("FAIL abort: ld/pm/err/busy/rdy %b%b%b%b%b, required 00100",
                     load_out, program_mode, error, busy, in_ready);
        end
        checks++;
        if (wr_cnt - w0 !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_writes: %0d writes %0d pending, required 3 0",
                     wr_cnt - w0, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clr_strobe();
        bit seen;
        do_start(5'd2);
        send(8'hA5, 1'b1);
        wait_load(seen);
        skip_hold = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || {program_mode, addr_out, data_out, load_out, in_ready,
                      busy, done, error, loaded_cnt} !== '0) begin
            errors++;
            $display("FAIL clr_strobe: seen %b pm %b addr %h data %h ld %b busy %b err %b cnt %0d, required 1 and all 0",
                     seen, program_mode, addr_out, data_out, load_out,
                     busy, error, loaded_cnt);
        end
        @(posedge clk); #1;
        skip_hold = 1'b0;
    endtask

    task automatic test_gaps_busy_start();
        logic [7:0] s = '0;
        logic [7:0] b;
        int dn;
        int w0 = wr_cnt;
        do_start(5'd3);
        for (int i = 0; i < 3; i++) begin
            b = 8'hD0 + 8'(i);
            s = s + b;
            send(b, 1'b1);
            for (int k = 1; k <= 5; k++) begin
                start  = 1'b1;
                len_in = 5'd5;
                @(negedge clk);
                checks++;
                if (in_ready !== (k >= 4)) begin
                    errors++;
                    $display("FAIL gap_ready byte %0d cyc %0d: %b, required %b",
                             i, k, in_ready, (k >= 4));
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        send(8'h00 - s, 1'b0);
        wait_done(dn);
        checks++;
        if (dn !== 1 || error !== 1'b0 || loaded_cnt !== 5'd3) begin
            errors++;
            $display("FAIL gaps: done %0d err %b cnt %0d, required 1 0 3",
                     dn, error, loaded_cnt);
        end
        checks++;
        if (wr_cnt - w0 !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL gaps_writes: %0d writes %0d pending, required 3 0",
                     wr_cnt - w0, exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        len_in   = '0;
        in_data  = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_checksum_ok();
        test_checksum_bad();
        test_bad_len();
        test_len16();
        test_abort();
        test_clr_strobe();
        test_gaps_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
